// File: rtl/axi_rd_scheduler_pkg.sv
// rtl/axi_rd_scheduler_pkg.sv - shared types and constants for the AXI read scheduler
package axi_rd_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_I = 2'd0,
        OWN_D = 2'd1,
        OWN_U = 2'd2
    } owner_t;

    localparam logic [3:0] DEF_ID_I       = 4'd0;
    localparam logic [3:0] DEF_ID_D       = 4'd1;
    localparam logic [3:0] DEF_ID_U       = 4'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_I = 0;
    localparam int GNT_D = 1;
    localparam int GNT_U = 2;

    function automatic owner_t gnt_to_owner(input logic [2:0] gnt);
        if (gnt[GNT_D]) return OWN_D;
        if (gnt[GNT_U]) return OWN_U;
        return OWN_I;
    endfunction

endpackage

// File: rtl/axi_rd_scheduler_if.sv
// rtl/axi_rd_scheduler_if.sv - requester-side and AXI-side read channel bundles
interface axi_rd_scheduler_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (output araddr, arlen, arsize, arvalid, rready,
                    input  arready, rdata, rlast, rvalid);
    modport slave  (input  araddr, arlen, arsize, arvalid, rready,
                    output arready, rdata, rlast, rvalid);
endinterface

interface axi_rd_bus_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (output arid, araddr, arlen, arsize, arburst, arvalid, rready,
                    input  arready, rid, rdata, rlast, rvalid);
    modport slave  (input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
                    output arready, rid, rdata, rlast, rvalid);
endinterface

// File: rtl/axi_rd_scheduler_rd_prio_sel.sv
// rtl/axi_rd_scheduler_rd_prio_sel.sv - fixed d > u > i priority with i starvation override
module rd_prio_sel
    import axi_rd_scheduler_pkg::*;
(
    input  logic       i_arvalid,
    input  logic       d_arvalid,
    input  logic       u_arvalid,
    input  logic       starve,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        if (starve && i_arvalid) begin
            gnt[GNT_I] = 1'b1;
        end else if (d_arvalid) begin
            gnt[GNT_D] = 1'b1;
        end else if (u_arvalid) begin
            gnt[GNT_U] = 1'b1;
        end else if (i_arvalid) begin
            gnt[GNT_I] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_rd_scheduler.sv
// rtl/axi_rd_scheduler.sv - shares one AXI read channel among i, d and u requesters
module axi_rd_scheduler
    import axi_rd_scheduler_pkg::*;
#(
    parameter int         STARVE_LIMIT = 4,
    parameter logic [3:0] ID_I         = DEF_ID_I,
    parameter logic [3:0] ID_D         = DEF_ID_D,
    parameter logic [3:0] ID_U         = DEF_ID_U
) (
    input  logic              clk,
    input  logic              rst,
    axi_rd_scheduler_if.slave i_port,
    axi_rd_scheduler_if.slave d_port,
    axi_rd_scheduler_if.slave u_port,
    axi_rd_bus_if.master      axi,
    output logic              id_err
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_t           state, state_nxt;
    owner_t           owner, win;
    logic [CNT_W-1:0] starve_cnt;
    logic [2:0]       gnt;
    logic             starve, any_req, grant, ar_hs, r_hs, own_rready;
    logic [3:0]       arid_q, sel_id;
    logic [31:0]      araddr_q, sel_addr;
    logic [7:0]       arlen_q, sel_len;
    logic [2:0]       arsize_q, sel_size;

    assign any_req = i_port.arvalid | d_port.arvalid | u_port.arvalid;
    assign starve  = (starve_cnt >= CNT_MAX);
    assign grant   = (state == IDLE) && any_req;
    assign ar_hs   = (state == ADDR) && axi.arready;
    assign r_hs    = (state == DATA) && axi.rvalid && own_rready;

    rd_prio_sel u_prio_sel (
        .i_arvalid (i_port.arvalid),
        .d_arvalid (d_port.arvalid),
        .u_arvalid (u_port.arvalid),
        .starve    (starve),
        .gnt       (gnt)
    );

    assign win = gnt_to_owner(gnt);

    always_comb begin
        sel_addr = i_port.araddr;
        sel_len  = i_port.arlen;
        sel_size = i_port.arsize;
        sel_id   = ID_I;
        case (win)
            OWN_D: begin
                sel_addr = d_port.araddr;
                sel_len  = d_port.arlen;
                sel_size = d_port.arsize;
                sel_id   = ID_D;
            end
            OWN_U: begin
                sel_addr = u_port.araddr;
                sel_len  = u_port.arlen;
                sel_size = u_port.arsize;
                sel_id   = ID_U;
            end
            default: ;
        endcase
    end

    always_comb begin
        own_rready = 1'b0;
        case (owner)
            OWN_I:   own_rready = i_port.rready;
            OWN_D:   own_rready = d_port.rready;
            OWN_U:   own_rready = u_port.rready;
            default: own_rready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ADDR;
            ADDR:    if (ar_hs) state_nxt = DATA;
            DATA:    if (r_hs && axi.rlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured once at grant; requesters may change them afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= OWN_I;
            arid_q   <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            arsize_q <= '0;
        end else if (grant) begin
            owner    <= win;
            arid_q   <= sel_id;
            araddr_q <= sel_addr;
            arlen_q  <= sel_len;
            arsize_q <= sel_size;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (gnt[GNT_I]) begin
                starve_cnt <= '0;
            end else if (i_port.arvalid && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_err <= 1'b0;
        end else if (r_hs && (axi.rid != arid_q)) begin
            id_err <= 1'b1;
        end
    end

    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = (state == ADDR);
    assign axi.rready  = (state == DATA) && own_rready;

    assign i_port.arready = (state == ADDR) && (owner == OWN_I) && axi.arready;
    assign d_port.arready = (state == ADDR) && (owner == OWN_D) && axi.arready;
    assign u_port.arready = (state == ADDR) && (owner == OWN_U) && axi.arready;

    assign i_port.rvalid = (state == DATA) && (owner == OWN_I) && axi.rvalid;
    assign d_port.rvalid = (state == DATA) && (owner == OWN_D) && axi.rvalid;
    assign u_port.rvalid = (state == DATA) && (owner == OWN_U) && axi.rvalid;

    assign i_port.rlast = (state == DATA) && (owner == OWN_I) && axi.rlast;
    assign d_port.rlast = (state == DATA) && (owner == OWN_D) && axi.rlast;
    assign u_port.rlast = (state == DATA) && (owner == OWN_U) && axi.rlast;

    assign i_port.rdata = axi.rdata;
    assign d_port.rdata = axi.rdata;
    assign u_port.rdata = axi.rdata;

endmodule

// File: tb/tb_axi_rd_scheduler.sv
// tb/tb_axi_rd_scheduler.sv - self-checking bench for axi_rd_scheduler
module tb_axi_rd_scheduler;
    import axi_rd_scheduler_pkg::*;

    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic rst;
    logic id_err;
    always #5 clk = ~clk;

    axi_rd_scheduler_if i_if ();
    axi_rd_scheduler_if d_if ();
    axi_rd_scheduler_if u_if ();
    axi_rd_bus_if       axi_if ();

    axi_rd_scheduler #(.STARVE_LIMIT(STARVE)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_port (i_if),
        .d_port (d_if),
        .u_port (u_if),
        .axi    (axi_if),
        .id_err (id_err)
    );

    logic       t_i, t_d, t_u, t_s;
    logic [2:0] t_gnt;
    rd_prio_sel u_sel (
        .i_arvalid (t_i),
        .d_arvalid (t_d),
        .u_arvalid (t_u),
        .starve    (t_s),
        .gnt       (t_gnt)
    );

    typedef struct packed {
        logic       i;
        logic       d;
        logic       u;
        logic       s;
        logic [2:0] gnt;
    } sel_vec_t;
    sel_vec_t sel_tab [16];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] req_addr [3];
    logic [7:0]  req_len  [3];
    logic [2:0]  req_size [3];
    logic        rr       [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic get_arready(input int p);
        case (p)
            0:       return i_if.arready;
            1:       return d_if.arready;
            default: return u_if.arready;
        endcase
    endfunction

    function automatic logic get_rvalid(input int p);
        case (p)
            0:       return i_if.rvalid;
            1:       return d_if.rvalid;
            default: return u_if.rvalid;
        endcase
    endfunction

    function automatic logic get_rlast(input int p);
        case (p)
            0:       return i_if.rlast;
            1:       return d_if.rlast;
            default: return u_if.rlast;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int p);
        case (p)
            0:       return i_if.rdata;
            1:       return d_if.rdata;
            default: return u_if.rdata;
        endcase
    endfunction

    task automatic set_req(input int p, input logic v);
        case (p)
            0: begin i_if.arvalid = v; i_if.araddr = req_addr[0]; i_if.arlen = req_len[0]; i_if.arsize = req_size[0]; end
            1: begin d_if.arvalid = v; d_if.araddr = req_addr[1]; d_if.arlen = req_len[1]; d_if.arsize = req_size[1]; end
            default: begin u_if.arvalid = v; u_if.araddr = req_addr[2]; u_if.arlen = req_len[2]; u_if.arsize = req_size[2]; end
        endcase
    endtask

    task automatic set_rready(input int p, input logic v);
        rr[p] = v;
        case (p)
            0:       i_if.rready = v;
            1:       d_if.rready = v;
            default: u_if.rready = v;
        endcase
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 3; p++) begin
            req_addr[p] = '0;
            req_len[p]  = '0;
            req_size[p] = '0;
            set_req(p, 1'b0);
            set_rready(p, 1'b0);
        end
        axi_if.arready = 1'b0;
        axi_if.rid     = '0;
        axi_if.rdata   = '0;
        axi_if.rlast   = 1'b0;
        axi_if.rvalid  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Expects ADDR with p's request on the bus; completes handshake and all beats
    task automatic issue_and_check(input int p, input string tag, input int bad_beat);
        int nb;
        nb = int'(req_len[p]) + 1;
        chk({tag, "_arvalid"}, axi_if.arvalid, 1);
        chk({tag, "_arid"}, axi_if.arid, p);
        chk({tag, "_araddr"}, axi_if.araddr, req_addr[p]);
        chk({tag, "_arlen"}, axi_if.arlen, req_len[p]);
        chk({tag, "_arsize"}, axi_if.arsize, req_size[p]);
        chk({tag, "_arburst"}, axi_if.arburst, 2'b01);
        axi_if.arready = 1'b1;
        #1;
        chk({tag, "_own_arready"}, get_arready(p), 1);
        chk({tag, "_oth_arready"}, get_arready((p + 1) % 3) | get_arready((p + 2) % 3), 0);
        step();
        axi_if.arready = 1'b0;
        set_req(p, 1'b0);
        set_rready(p, 1'b1);
        for (int k = 0; k < nb; k++) begin
            axi_if.rvalid = 1'b1;
            axi_if.rid    = (k == bad_beat) ? 4'((p + 1) % 3) : 4'(p);
            axi_if.rdata  = $urandom;
            axi_if.rlast  = (k == nb - 1);
            #1;
            chk({tag, "_own_rvalid"}, get_rvalid(p), 1);
            chk({tag, "_own_rlast"}, get_rlast(p), (k == nb - 1));
            chk({tag, "_own_rdata"}, get_rdata(p), axi_if.rdata);
            chk({tag, "_oth_rvalid"}, get_rvalid((p + 1) % 3) | get_rvalid((p + 2) % 3), 0);
            chk({tag, "_rready"}, axi_if.rready, 1);
            step();
        end
        axi_if.rvalid = 1'b0;
        axi_if.rlast  = 1'b0;
        set_rready(p, 1'b0);
    endtask

    initial begin
        bit          m_busy, m_ar_done, g_nxt, ar_nxt, r_nxt, last_nxt, in_addr, in_data;
        bit          pend [3];
        int          m_owner, m_starve, m_beat, w_nxt;
        logic [7:0]  m_len;

        // priority selector: exhaustive table
        sel_tab[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        sel_tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001};
        sel_tab[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010};
        sel_tab[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b100};
        sel_tab[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b010};
        sel_tab[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b100};
        sel_tab[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b010};
        sel_tab[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b010};
        sel_tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
        sel_tab[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b001};
        sel_tab[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010};
        sel_tab[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b100};
        sel_tab[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b001};
        sel_tab[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b001};
        sel_tab[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010};
        sel_tab[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b001};
        for (int k = 0; k < 16; k++) begin
            t_i = sel_tab[k].i;
            t_d = sel_tab[k].d;
            t_u = sel_tab[k].u;
            t_s = sel_tab[k].s;
            #1;
            chk($sformatf("prio_vec%0d", k), t_gnt, sel_tab[k].gnt);
        end

        // reset state, with AXI arready and stale rvalid driven high
        rst = 1'b1;
        clear_inputs();
        axi_if.arready = 1'b1;
        axi_if.rvalid  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arvalid", axi_if.arvalid, 0);
        chk("rst_rready", axi_if.rready, 0);
        chk("rst_arid", axi_if.arid, 0);
        chk("rst_araddr", axi_if.araddr, 0);
        chk("rst_arlen", axi_if.arlen, 0);
        chk("rst_arsize", axi_if.arsize, 0);
        chk("rst_arburst", axi_if.arburst, 2'b01);
        chk("rst_id_err", id_err, 0);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("rst_arready%0d", p), get_arready(p), 0);
            chk($sformatf("rst_rvalid%0d", p), get_rvalid(p), 0);
        end

        // single d burst of four beats
        do_reset();
        req_addr[1] = 32'h1FC0_0000;
        req_len[1]  = 8'd3;
        req_size[1] = 3'd2;
        set_req(1, 1'b1);
        #1;
        chk("s1_arvalid_n", axi_if.arvalid, 0);
        step();
        issue_and_check(1, "s1", -1);
        chk("s1_idle_arvalid", axi_if.arvalid, 0);
        chk("s1_idle_rready", axi_if.rready, 0);
        chk("s1_id_err", id_err, 0);

        // all three at once: d, u, i with one idle cycle between
        do_reset();
        for (int p = 0; p < 3; p++) begin
            req_addr[p] = 32'h1000 * (p + 1);
            req_size[p] = 3'd2;
            set_req(p, 1'b1);
        end
        step();
        issue_and_check(1, "s2d", -1);
        chk("s2_gap1", axi_if.arvalid, 0);
        step();
        issue_and_check(2, "s2u", -1);
        chk("s2_gap2", axi_if.arvalid, 0);
        step();
        issue_and_check(0, "s2i", -1);

        // starvation guard: d wins four times, then i, then counter cleared
        do_reset();
        req_addr[0] = 32'h0000_0100;
        req_addr[1] = 32'h0000_0200;
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        for (int g = 0; g < STARVE; g++) begin
            step();
            issue_and_check(1, $sformatf("s3d%0d", g), -1);
            set_req(1, 1'b1);
        end
        step();
        issue_and_check(0, "s3i", -1);
        set_req(0, 1'b1);
        step();
        issue_and_check(1, "s3d_after", -1);
        clear_inputs();

        // arready stalls for five cycles
        do_reset();
        req_addr[2] = 32'hA5A5_0040;
        req_len[2]  = 8'd1;
        req_size[2] = 3'd3;
        set_req(2, 1'b1);
        step();
        for (int c = 0; c < 5; c++) begin
            chk("s4_arvalid", axi_if.arvalid, 1);
            chk("s4_araddr", axi_if.araddr, 32'hA5A5_0040);
            chk("s4_arlen", axi_if.arlen, 1);
            chk("s4_arsize", axi_if.arsize, 3);
            chk("s4_arid", axi_if.arid, 2);
            #1;
            chk("s4_u_arready", get_arready(2), 0);
            step();
        end
        issue_and_check(2, "s4", -1);

        // rid mismatch on beat 1 of a d burst
        do_reset();
        req_addr[1] = 32'h0000_3000;
        req_len[1]  = 8'd1;
        set_req(1, 1'b1);
        step();
        issue_and_check(1, "s5", 1);
        chk("s5_id_err", id_err, 1);
        set_req(1, 1'b1);
        step();
        issue_and_check(1, "s5b", -1);
        chk("s5_id_err_sticky", id_err, 1);

        // reset mid-burst, then a fresh u request
        do_reset();
        req_addr[1] = 32'h0000_4000;
        req_len[1]  = 8'd3;
        set_req(1, 1'b1);
        step();
        axi_if.arready = 1'b1;
        step();
        axi_if.arready = 1'b0;
        set_req(1, 1'b0);
        set_rready(1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            axi_if.rvalid = 1'b1;
            axi_if.rid    = 4'd1;
            axi_if.rdata  = 32'hBEEF_0000 + k;
            #1;
            chk("s6_beat_rvalid", get_rvalid(1), 1);
            if (k < 2) step();
        end
        rst = 1'b1;
        #1;
        chk("s6_arvalid", axi_if.arvalid, 0);
        chk("s6_rready", axi_if.rready, 0);
        chk("s6_d_rvalid", get_rvalid(1), 0);
        step();
        chk("s6_edge_rready", axi_if.rready, 0);
        chk("s6_edge_rvalid", get_rvalid(0) | get_rvalid(1) | get_rvalid(2), 0);
        chk("s6_araddr", axi_if.araddr, 0);
        chk("s6_arid", axi_if.arid, 0);
        rst = 1'b0;
        #1;
        chk("s6_idle_ignore_rready", axi_if.rready, 0);
        chk("s6_idle_ignore_rvalid", get_rvalid(1), 0);
        clear_inputs();
        req_addr[2] = 32'h0000_5000;
        req_len[2]  = 8'd2;
        set_req(2, 1'b1);
        step();
        issue_and_check(2, "s6u", -1);

        // randomized traffic against a transaction-level model
        do_reset();
        m_busy = 0; m_ar_done = 0; m_owner = 0; m_starve = 0; m_beat = 0; m_len = '0;
        g_nxt = 0; ar_nxt = 0; r_nxt = 0; last_nxt = 0; w_nxt = 0;
        for (int p = 0; p < 3; p++) pend[p] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            if (g_nxt) begin
                m_busy = 1; m_ar_done = 0; m_owner = w_nxt; m_beat = 0;
            end
            if (ar_nxt) begin
                m_ar_done = 1;
                pend[m_owner] = 0;
            end
            if (r_nxt) begin
                m_beat++;
                if (last_nxt) m_busy = 0;
            end
            in_addr = m_busy && !m_ar_done;
            in_data = m_busy && m_ar_done;

            chk("rnd_arvalid", axi_if.arvalid, in_addr);
            if (in_addr) begin
                chk("rnd_arid", axi_if.arid, m_owner);
                chk("rnd_araddr", axi_if.araddr, req_addr[m_owner]);
                chk("rnd_arlen", axi_if.arlen, m_len);
                chk("rnd_arsize", axi_if.arsize, req_size[m_owner]);
            end
            chk("rnd_id_err", id_err, 0);

            for (int p = 0; p < 3; p++) begin
                if (!pend[p] && $urandom_range(3) == 0) begin
                    pend[p]     = 1;
                    req_addr[p] = $urandom;
                    req_len[p]  = 8'($urandom_range(3));
                    req_size[p] = 3'($urandom_range(2));
                end
                set_req(p, pend[p]);
                set_rready(p, $urandom_range(3) != 0);
            end
            axi_if.arready = 1'($urandom_range(1));
            if (in_data) begin
                axi_if.rvalid = ($urandom_range(9) < 7);
                axi_if.rid    = 4'(m_owner);
                axi_if.rlast  = (m_beat == int'(m_len));
            end else begin
                axi_if.rvalid = ($urandom_range(3) == 0);
                axi_if.rid    = 4'($urandom);
                axi_if.rlast  = 1'($urandom_range(1));
            end
            axi_if.rdata = $urandom;
            #1;

            for (int p = 0; p < 3; p++) begin
                chk("rnd_arready", get_arready(p), in_addr && (p == m_owner) && axi_if.arready);
                chk("rnd_rvalid", get_rvalid(p), in_data && (p == m_owner) && axi_if.rvalid);
                chk("rnd_rlast", get_rlast(p), in_data && (p == m_owner) && axi_if.rlast);
                chk("rnd_rdata", get_rdata(p), axi_if.rdata);
            end
            chk("rnd_rready", axi_if.rready, in_data && rr[m_owner]);

            g_nxt = !m_busy && (pend[0] || pend[1] || pend[2]);
            if (g_nxt) begin
                if (m_starve >= STARVE && pend[0]) w_nxt = 0;
                else if (pend[1])                  w_nxt = 1;
                else if (pend[2])                  w_nxt = 2;
                else                               w_nxt = 0;
                if (w_nxt == 0)   m_starve = 0;
                else if (pend[0]) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
                m_len = req_len[w_nxt];
            end
            ar_nxt   = in_addr && axi_if.arready;
            r_nxt    = in_data && axi_if.rvalid && rr[m_owner];
            last_nxt = r_nxt && axi_if.rlast;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
